rv64i_dataflow: RTL and testbench

- Single-cycle-style RV64I datapath controlled externally by the control unit.
- Contains:
  - PC register and next-PC logic
  - 32x64 register file
  - immediate extender
  - 64-bit ALU with branch flags
  - load-data extender
  - register write-back mux
- Fetches through `instruction_address`/`instruction` and accesses data memory through `data_address`/`write_data`/`read_data`.
- Exposes decoded fields and flags to the control unit.

---
 rtl/rv64i_dataflow_if.sv | 19 +
 rtl/rv64i_dataflow.sv | 157 +++++++++++++++
 tb/tb_rv64i_dataflow.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv64i_dataflow_if.sv
// Fetch and data-memory bus between the RV64I datapath (master) and its memories (slave).
// Purely combinational: no valid/ready; memories return instruction/read_data in the same cycle.
interface rv64i_dataflow_if;
  logic [63:0] instruction_address;
  logic [31:0] instruction;
  logic [63:0] data_address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  modport master (
    output instruction_address, data_address, write_data,
    input  instruction, read_data
  );

  modport slave (
    input  instruction_address, data_address, write_data,
    output instruction, read_data
  );
endinterface

// File: rtl/rv64i_dataflow.sv
// Single-cycle RV64I datapath steered by an external control unit.
// Optional DATAFLOW_MISALIGN_CHECK_EN adds a misaligned output that blocks misaligned PC loads.
module rv64i_dataflow #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  rv64i_dataflow_if.master bus,
  input  logic        alua_src,
  input  logic        alub_src,
  input  logic        aluy_src,
  input  logic [2:0]  alu_src,
  input  logic        carry_in,
  input  logic        arithmetic,
  input  logic        alupc_src,
  input  logic        pc_src,
  input  logic        pc_enable,
  input  logic [2:0]  read_data_src,
  input  logic [1:0]  write_register_src,
  input  logic        write_register_enable,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        zero,
  output logic        negative,
  output logic        carry_out,
  output logic        overflow,
  output logic [63:0] db_reg_data
`ifdef DATAFLOW_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  logic [63:0] pc;
  logic [63:0] regs [32];
  logic [31:0] inst;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [63:0] rs1, rs2, imm;
  logic [63:0] alu_a, alu_b, alu_raw, alu_y;
  logic [63:0] load_ext, pc_plus4, target, next_pc;
  logic [64:0] diff;
  logic signed [31:0] a_w;
  logic        pc_load;

  assign inst    = bus.instruction;
  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign rs1_idx = inst[19:15];
  assign rs2_idx = inst[24:20];
  assign rd_idx  = inst[11:7];

  assign rs1 = (rs1_idx == 5'd0) ? 64'd0 : regs[rs1_idx];
  assign rs2 = (rs2_idx == 5'd0) ? 64'd0 : regs[rs2_idx];

  always_comb begin
    imm = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111:
        imm = {{52{inst[31]}}, inst[31:20]};
      7'b0100011: imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      7'b1100011: imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      7'b1101111: imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:    imm = '0;
    endcase
  end

  assign alu_a = alua_src ? pc  : rs1;
  assign alu_b = alub_src ? imm : rs2;
  assign a_w   = alu_a[31:0];

  // W shifts work on the low word only; the final sign-extension is applied below.
  always_comb begin
    alu_raw = '0;
    case (alu_src)
      3'b000: alu_raw = carry_in ? (alu_a + ~alu_b + 64'd1) : (alu_a + alu_b);
      3'b001: begin
        if (aluy_src) alu_raw = {32'b0, alu_a[31:0] << alu_b[4:0]};
        else          alu_raw = alu_a << alu_b[5:0];
      end
      3'b010: alu_raw = {63'd0, $signed(alu_a) < $signed(alu_b)};
      3'b011: alu_raw = {63'd0, alu_a < alu_b};
      3'b100: alu_raw = alu_a ^ alu_b;
      3'b101: begin
        if (aluy_src) begin
          if (arithmetic) alu_raw = {32'b0, a_w >>> alu_b[4:0]};
          else            alu_raw = {32'b0, alu_a[31:0] >> alu_b[4:0]};
        end else begin
          if (arithmetic) alu_raw = $signed(alu_a) >>> alu_b[5:0];
          else            alu_raw = alu_a >> alu_b[5:0];
        end
      end
      3'b110: alu_raw = alu_a & alu_b;
      3'b111: alu_raw = alu_a | alu_b;
      default: alu_raw = '0;
    endcase
  end

  assign alu_y = aluy_src ? {{32{alu_raw[31]}}, alu_raw[31:0]} : alu_raw;

  // Branch flags always compare the two register operands, independent of ALU muxing.
  assign diff      = {1'b0, rs1} + {1'b0, ~rs2} + 65'd1;
  assign carry_out = diff[64];
  assign zero      = (diff[63:0] == 64'd0);
  assign negative  = diff[63];
  assign overflow  = (rs1[63] != rs2[63]) & (diff[63] != rs1[63]);

  always_comb begin
    load_ext = bus.read_data;
    case (read_data_src[1:0])
      2'b00: load_ext = {{56{read_data_src[2] & bus.read_data[7]}},  bus.read_data[7:0]};
      2'b01: load_ext = {{48{read_data_src[2] & bus.read_data[15]}}, bus.read_data[15:0]};
      2'b10: load_ext = {{32{read_data_src[2] & bus.read_data[31]}}, bus.read_data[31:0]};
      default: load_ext = bus.read_data;
    endcase
  end

  assign pc_plus4 = pc + 64'd4;

  always_comb begin
    db_reg_data = alu_y;
    case (write_register_src)
      2'b00: db_reg_data = alu_y;
      2'b01: db_reg_data = load_ext;
      2'b10: db_reg_data = pc_plus4;
      2'b11: db_reg_data = imm;
      default: db_reg_data = alu_y;
    endcase
  end

  assign target  = alupc_src ? {alu_y[63:1], 1'b0} : (pc + imm);
  assign next_pc = pc_src ? target : pc_plus4;

`ifdef DATAFLOW_MISALIGN_CHECK_EN
  assign misaligned = pc_src & (target[1:0] != 2'b00);
  assign pc_load    = pc_enable & ~misaligned;
`else
  assign pc_load    = pc_enable;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (pc_load) pc <= next_pc;
      if (write_register_enable && (rd_idx != 5'd0)) regs[rd_idx] <= db_reg_data;
    end
  end

  assign bus.instruction_address = pc;
  assign bus.data_address        = alu_y;
  assign bus.write_data          = rs2;

endmodule

// File: tb/tb_rv64i_dataflow.sv
// Bench for rv64i_dataflow: directed vector table, hand sequences and randomized ops vs a model.
module tb_rv64i_dataflow;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_RW   = 7'b0111011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_IW   = 7'b0011011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  rv64i_dataflow_if bus();

  logic        alua_src, alub_src, aluy_src, carry_in, arithmetic, alupc_src;
  logic        pc_src, pc_enable, write_register_enable;
  logic [2:0]  alu_src, read_data_src;
  logic [1:0]  write_register_src;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        zero, negative, carry_out, overflow;
  logic [63:0] db_reg_data;
`ifdef DATAFLOW_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  rv64i_dataflow #(.RESET_PC(64'd0)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .alua_src(alua_src), .alub_src(alub_src), .aluy_src(aluy_src),
    .alu_src(alu_src), .carry_in(carry_in), .arithmetic(arithmetic),
    .alupc_src(alupc_src), .pc_src(pc_src), .pc_enable(pc_enable),
    .read_data_src(read_data_src), .write_register_src(write_register_src),
    .write_register_enable(write_register_enable),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
    .db_reg_data(db_reg_data)
`ifdef DATAFLOW_MISALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  typedef struct {
    logic       alua, alub, aluy;
    logic [2:0] op;
    logic       cin, arith, alupc, psrc, pen;
    logic [2:0] rds;
    logic [1:0] wbs;
    logic       we;
  } ctrl_t;

  typedef struct {
    logic [31:0] inst;
    ctrl_t       c;
    logic [63:0] rdata;
    logic [63:0] exp_db;
    logic [63:0] exp_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  vec_t        vq[$];
  logic [63:0] m_regs [32];
  logic [63:0] m_pc;

  function automatic ctrl_t mkc(input int alua, alub, aluy, op, cin, arith, alupc, psrc, pen,
                                rds, wbs, we);
    ctrl_t c;
    c.alua = alua[0]; c.alub = alub[0]; c.aluy = aluy[0]; c.op = 3'(op);
    c.cin = cin[0]; c.arith = arith[0]; c.alupc = alupc[0]; c.psrc = psrc[0];
    c.pen = pen[0]; c.rds = 3'(rds); c.wbs = 2'(wbs); c.we = we[0];
    return c;
  endfunction

  function automatic logic [31:0] enc_r(input int f7, rs2, rs1, f3, rd, input logic [6:0] opc);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, rs1, f3, rd, input logic [6:0] opc);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, rd, input logic [6:0] opc);
    return {20'(imm), 5'(rd), opc};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, rs2, rs1, f3, input logic [6:0] opc);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], opc};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, rd, input logic [6:0] opc);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), opc};
  endfunction

  // Reference ALU straight from the operation list; W ops keep the low word and sign-extend it.
  function automatic logic [63:0] model_alu(input logic [2:0] op, input logic [63:0] a, b,
                                            input logic sub, arith, w);
    logic [63:0] r;
    logic [63:0] aw;
    int sh;
    sh = w ? int'(b[4:0]) : int'(b[5:0]);
    aw = {{32{a[31]}}, a[31:0]};
    case (op)
      3'd0: r = sub ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (w && arith)  r = $signed(aw) >>> sh;
        else if (w)      r = {32'd0, a[31:0]} >> sh;
        else if (arith)  r = $signed(a) >>> sh;
        else             r = a >> sh;
      end
      3'd6: r = a & b;
      default: r = a | b;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] d, input logic [2:0] rds);
    int sh;
    logic [63:0] t;
    sh = 64 - (8 << int'(rds[1:0]));
    t = d << sh;
    if (rds[2] && rds[1:0] != 2'b11) return $signed(t) >>> sh;
    return t >> sh;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input ctrl_t c, input logic [63:0] rdata);
    bus.instruction = inst; bus.read_data = rdata;
    alua_src = c.alua; alub_src = c.alub; aluy_src = c.aluy; alu_src = c.op;
    carry_in = c.cin; arithmetic = c.arith; alupc_src = c.alupc; pc_src = c.psrc;
    pc_enable = c.pen; read_data_src = c.rds; write_register_src = c.wbs;
    write_register_enable = c.we;
  endtask

  task automatic commit();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(32'd0, mkc(0,0,0,0,0,0,0,0,0,0,0,0), 64'd0);
    reset = 1'b1;
    commit();
    reset = 1'b0;
    m_pc = 64'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
  endtask

  task automatic add_vec(input logic [31:0] inst, input ctrl_t c, input logic [63:0] rdata,
                         input logic [63:0] exp_db, input logic [63:0] exp_pc);
    vec_t v;
    v.inst = inst; v.c = c; v.rdata = rdata; v.exp_db = exp_db; v.exp_pc = exp_pc;
    vq.push_back(v);
  endtask

  task automatic run_random(input int n);
    logic [31:0] inst;
    logic [63:0] a, b, rdata, exp_db, exp_addr, nxt, off;
    logic [6:0]  opc;
    logic [2:0]  op, rds;
    logic [4:0]  rs1, rs2f, rd;
    logic        w, useimm, sub, arith, psrc;
    int          kind, imm_i;
    for (int k = 0; k < n; k++) begin
      kind  = int'($urandom_range(0, 9));
      rs1   = 5'($urandom_range(0, 31));
      rd    = 5'($urandom_range(0, 31));
      imm_i = int'($urandom_range(0, 4095)) - 2048;
      rdata = {$urandom, $urandom};
      psrc  = 1'b0;
      if (kind < 7) begin
        w = 1'($urandom_range(0, 1)); useimm = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        sub = (op == 3'd0) && 1'($urandom_range(0, 1));
        arith = (op == 3'd5) && 1'($urandom_range(0, 1));
        opc = useimm ? (w ? OP_IW : OP_I) : (w ? OP_RW : OP_R);
        if (useimm) inst = enc_i(imm_i, int'(rs1), int'(op), int'(rd), opc);
        else inst = enc_r((sub | arith) ? 32 : 0, int'($urandom_range(0, 31)), int'(rs1),
                          int'(op), int'(rd), opc);
        rs2f = inst[24:20];
        a = m_regs[rs1];
        b = useimm ? 64'(longint'(imm_i)) : m_regs[rs2f];
        exp_db = model_alu(op, a, b, sub, arith, w);
        exp_addr = exp_db;
        drive(inst, mkc(0, int'(useimm), int'(w), int'(op), int'(sub), int'(arith), 0, 0, 1,
                        0, 0, 1), rdata);
      end else if (kind < 9) begin
        rds = 3'($urandom_range(0, 7));
        op = rds;
        inst = enc_i(imm_i, int'(rs1), int'(rds), int'(rd), OP_LD);
        rs2f = inst[24:20];
        exp_addr = m_regs[rs1] + 64'(longint'(imm_i));
        exp_db = model_load(rdata, rds);
        drive(inst, mkc(0, 1, 0, 0, 0, 0, 0, 0, 1, int'(rds), 1, 1), rdata);
      end else begin
        imm_i = int'($urandom_range(0, 2047)) * 4 - 4096;
        psrc = 1'($urandom_range(0, 1));
        rs2f = 5'($urandom_range(0, 31));
        op = 3'd0;
        inst = enc_b(imm_i, int'(rs2f), int'(rs1), 0, OP_BR);
        exp_db = m_regs[rs1] - m_regs[rs2f];
        exp_addr = exp_db;
        drive(inst, mkc(0, 0, 0, 0, 1, 0, 0, int'(psrc), 1, 0, 0, 0), rdata);
      end
      #1;
      exp_q.push_back(exp_db);
      check("rnd_db", db_reg_data, exp_q.pop_front());
      check("rnd_addr", bus.data_address, exp_addr);
      check("rnd_wdata", bus.write_data, m_regs[rs2f]);
      check("rnd_fields", {47'd0, funct7, funct3, opcode}, {47'd0, inst[31:25], op, inst[6:0]});
      a = m_regs[rs1]; b = m_regs[rs2f];
      check("rnd_flags", {60'd0, zero, negative, carry_out, overflow},
            {60'd0, a == b, ((a - b) >> 63) == 64'd1, a >= b,
             (($signed(a) < $signed(b)) != (((a - b) >> 63) == 64'd1))});
      off = 64'(longint'(imm_i));
      nxt = psrc ? m_pc + off : m_pc + 64'd4;
      commit();
      if (kind < 9 && rd != 5'd0) m_regs[rd] = exp_db;
      m_pc = nxt;
      check("rnd_pc", bus.instruction_address, m_pc);
    end
  endtask

  initial begin
    ctrl_t ci, cr, cw, ciw, cld;
    logic [63:0] r;
    logic [2:0] rds;
    ci  = mkc(0,1,0,0,0,0,0,0,1,0,0,1);
    cr  = mkc(0,0,0,0,0,0,0,0,1,0,0,1);
    cw  = mkc(0,0,1,0,0,0,0,0,1,0,0,1);
    ciw = mkc(0,1,1,0,0,0,0,0,1,0,0,1);
    cld = mkc(0,1,0,0,0,0,0,0,1,3'b100,1,1);

    add_vec(enc_i(-5, 0, 0, 1, OP_I), ci, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd4);
    add_vec(enc_r(0, 0, 1, 0, 2, OP_R), cr, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd8);
    add_vec(enc_u(32'h80000, 1, OP_LUI), mkc(0,0,0,0,0,0,0,0,1,0,3,1), 64'd0,
            64'hFFFF_FFFF_8000_0000, 64'd12);
    add_vec(enc_i(-1, 1, 0, 1, OP_IW), ciw, 64'd0, 64'h0000_0000_7FFF_FFFF, 64'd16);
    add_vec(enc_i(1, 0, 0, 2, OP_I), ci, 64'd0, 64'd1, 64'd20);
    add_vec(enc_r(0, 2, 1, 0, 3, OP_RW), cw, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd24);
    add_vec(enc_i(0, 0, 0, 3, OP_LD), cld, 64'h80, 64'hFFFF_FFFF_FFFF_FF80, 64'd28);
    add_vec(enc_i(0, 0, 4, 4, OP_LD), mkc(0,1,0,0,0,0,0,0,1,0,1,1), 64'h80, 64'h80, 64'd32);
    add_vec(enc_i(0, 0, 1, 5, OP_LD), mkc(0,1,0,0,0,0,0,0,1,3'b101,1,1),
            64'h1234_5678_9ABC_8001, 64'hFFFF_FFFF_FFFF_8001, 64'd36);
    add_vec(enc_i(0, 0, 6, 6, OP_LD), mkc(0,1,0,0,0,0,0,0,1,3'b010,1,1),
            64'h1234_5678_9ABC_8001, 64'h0000_0000_9ABC_8001, 64'd40);
    add_vec(enc_u(1, 7, OP_AUI), mkc(1,1,0,0,0,0,0,0,1,0,0,1), 64'd0, 64'h1028, 64'd44);
    add_vec(enc_r(32, 2, 1, 0, 8, OP_R), mkc(0,0,0,0,1,0,0,0,1,0,0,1), 64'd0,
            64'h7FFF_FFFE, 64'd48);
    add_vec(enc_r(32, 2, 3, 5, 9, OP_R), mkc(0,0,0,5,0,1,0,0,1,0,0,1), 64'd0,
            64'hFFFF_FFFF_FFFF_FFC0, 64'd52);
    add_vec(enc_i(4, 3, 5, 10, OP_IW), mkc(0,1,1,5,0,0,0,0,1,0,0,1), 64'd0,
            64'h0FFF_FFF8, 64'd56);
    add_vec(enc_i(32'h404, 3, 5, 11, OP_IW), mkc(0,1,1,5,0,1,0,0,1,0,0,1), 64'd0,
            64'hFFFF_FFFF_FFFF_FFF8, 64'd60);
    add_vec(enc_r(0, 2, 3, 2, 12, OP_R), mkc(0,0,0,2,0,0,0,0,1,0,0,1), 64'd0, 64'd1, 64'd64);
    add_vec(enc_r(0, 2, 3, 3, 13, OP_R), mkc(0,0,0,3,0,0,0,0,1,0,0,1), 64'd0, 64'd0, 64'd68);
    add_vec(enc_i(7, 0, 0, 0, OP_I), ci, 64'd0, 64'd7, 64'd72);
    add_vec(enc_r(0, 0, 0, 0, 14, OP_R), cr, 64'd0, 64'd0, 64'd76);
    add_vec(enc_i(9, 0, 0, 15, OP_I), mkc(0,1,0,0,0,0,0,0,0,0,0,0), 64'd0, 64'd9, 64'd76);
    add_vec(enc_r(0, 0, 15, 0, 16, OP_R), cr, 64'd0, 64'd0, 64'd80);

    do_reset();
    check("reset_pc", bus.instruction_address, 64'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].inst, vq[i].c, vq[i].rdata);
      #1;
      exp_q.push_back(vq[i].exp_db);
      check($sformatf("vec%0d_db", i), db_reg_data, exp_q.pop_front());
      commit();
      check($sformatf("vec%0d_pc", i), bus.instruction_address, vq[i].exp_pc);
    end

    // Reset must clear registers written above (x5 holds a load result here).
    do_reset();
    check("reset_pc2", bus.instruction_address, 64'd0);
    drive(enc_r(0, 5, 5, 0, 0, OP_R), mkc(0,0,0,0,0,0,0,0,0,0,0,0), 64'd0);
    #1;
    check("reset_x5_rs1", bus.data_address, 64'd0);
    check("reset_x5_rs2", bus.write_data, 64'd0);

    for (int t = 0; t < 2; t++) begin
      do_reset();
      for (int j = 0; j < 2; j++) begin
        drive(enc_i(0, 0, 0, 0, OP_I), ci, 64'd0);
        commit();
      end
      check("beq_start_pc", bus.instruction_address, 64'd8);
      drive(enc_b(16, 2, 1, 0, OP_BR), mkc(0,0,0,0,1,0,0,1 - t,1,0,0,0), 64'd0);
      #1;
      check("beq_flags", {60'd0, zero, negative, carry_out, overflow}, 64'b1010);
      commit();
      check(t == 0 ? "beq_taken_pc" : "beq_fall_pc", bus.instruction_address,
            t == 0 ? 64'd24 : 64'd12);
    end

    do_reset();
    drive(enc_i(32'h100, 0, 0, 5, OP_I), ci, 64'd0);
    commit();
    drive(enc_j(32'h3C, 0, OP_JAL), mkc(0,0,0,0,0,0,0,1,1,0,2,0), 64'd0);
    commit();
    check("jal_pc", bus.instruction_address, 64'h40);
    drive(enc_i(3, 5, 0, 1, OP_JALR), mkc(0,1,0,0,0,0,1,1,1,0,2,1), 64'd0);
    #1;
    check("jalr_db", db_reg_data, 64'h44);
    check("jalr_addr", bus.data_address, 64'h103);
`ifdef DATAFLOW_MISALIGN_CHECK_EN
    check("jalr_misaligned", {63'd0, misaligned}, 64'd1);
    commit();
    check("jalr_pc", bus.instruction_address, 64'h40);
`else
    commit();
    check("jalr_pc", bus.instruction_address, 64'h102);
`endif
    drive(enc_r(0, 0, 1, 0, 0, OP_R), mkc(0,0,0,0,0,0,0,0,0,0,0,0), 64'd0);
    #1;
    check("jalr_x1", bus.data_address, 64'h44);

    do_reset();
    for (int rd = 1; rd < 32; rd++) begin
      r = {$urandom, $urandom};
      rds = {1'($urandom_range(0, 1)), 2'b11};
      drive(enc_i(0, 0, 3, rd, OP_LD), mkc(0,1,0,0,0,0,0,0,1,int'(rds),1,1), r);
      #1;
      check("init_ld", db_reg_data, r);
      commit();
      m_regs[rd] = r;
      m_pc = m_pc + 64'd4;
    end
    run_random(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
